// File: rtl/game_stats_pkg.sv
// Shared types, widths and default tuning for the game statistics block.
package game_stats_pkg;

   typedef enum logic [1:0] {
      StPlay   = 2'd0,
      StInvuln = 2'd1,
      StOver   = 2'd2
   } state_e;

   localparam int unsigned ScoreW = 7;
   localparam int unsigned LivesW = 4;

   localparam int unsigned DefStartLives   = 3;
   localparam int unsigned DefMaxLives     = 9;
   localparam int unsigned DefScoreMax     = 99;
   localparam int unsigned DefBonusScore   = 50;
   localparam int unsigned DefInvulnCycles = 50000;
   localparam int unsigned DefDispDiv      = 100000;

endpackage

// File: rtl/game_stats_if.sv
// Event inputs and display-facing status outputs of game_stats.
interface game_stats_if;
   import game_stats_pkg::*;

   logic              new_game;
   logic              alien_hit;
   logic [3:0]        alien_pts;
   logic              player_hit;
   logic [LivesW-1:0] lives;
   logic [ScoreW-1:0] score;
   logic              game_over;
   logic              life_lost;
   logic              clk_display;

   modport master (
      output new_game, alien_hit, alien_pts, player_hit,
      input  lives, score, game_over, life_lost, clk_display
   );

   modport slave (
      input  new_game, alien_hit, alien_pts, player_hit,
      output lives, score, game_over, life_lost, clk_display
   );

endinterface

// File: rtl/game_stats_tick_divider.sv
// Free-running divider producing a registered one-cycle strobe every Div clocks.
module tick_divider #(
   parameter int unsigned Div = 100000
) (
   input  logic clk,
   input  logic arst,
   output logic tick
);

   localparam int unsigned   CntW = $clog2(Div);
   localparam logic [CntW-1:0] Last = CntW'(Div - 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            tick_q, tick_d;

   always_comb begin
      cnt_d  = (cnt_q == Last) ? '0 : cnt_q + CntW'(1);
      tick_d = (cnt_q == Last);
   end

   always_ff @(posedge clk) begin
      if (arst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/game_stats.sv
// Score/lives bookkeeping with invulnerability window, one-shot bonus life and game-over,
// plus the display refresh strobe.
module game_stats
   import game_stats_pkg::*;
#(
   parameter int unsigned StartLives   = DefStartLives,
   parameter int unsigned MaxLives     = DefMaxLives,
   parameter int unsigned ScoreMax     = DefScoreMax,
   parameter int unsigned BonusScore   = DefBonusScore,
   parameter int unsigned InvulnCycles = DefInvulnCycles,
   parameter int unsigned DispDiv      = DefDispDiv
) (
   input logic         clk,
   input logic         arst,
   game_stats_if.slave bus
);

   localparam int unsigned InvW = (InvulnCycles > 1) ? $clog2(InvulnCycles) : 1;

   localparam logic [ScoreW-1:0] ScoreMaxV   = ScoreW'(ScoreMax);
   localparam logic [ScoreW-1:0] BonusV      = ScoreW'(BonusScore);
   localparam logic [LivesW-1:0] StartLivesV = LivesW'(StartLives);
   localparam logic [LivesW-1:0] MaxLivesV   = LivesW'(MaxLives);
   localparam logic [InvW-1:0]   InvLoad     = InvW'(InvulnCycles - 1);

   state_e            state_q, state_d;
   logic [LivesW-1:0] lives_q, lives_d;
   logic [ScoreW-1:0] score_q, score_d;
   logic              bonus_given_q, bonus_given_d;
   logic [InvW-1:0]   invuln_q, invuln_d;
   logic              game_over_q, game_over_d;
   logic              life_lost_q, life_lost_d;

   logic [ScoreW:0]   sum;
   logic [ScoreW-1:0] score_sat;
   logic [LivesW-1:0] lives_after_hit;
   logic              clk_display;

   always_comb begin
      sum       = {1'b0, score_q} + {{(ScoreW - 3){1'b0}}, bus.alien_pts};
      score_sat = (sum > {1'b0, ScoreMaxV}) ? ScoreMaxV : sum[ScoreW-1:0];

      state_d         = state_q;
      lives_d         = lives_q;
      score_d         = score_q;
      bonus_given_d   = bonus_given_q;
      invuln_d        = invuln_q;
      game_over_d     = game_over_q;
      life_lost_d     = 1'b0;
      lives_after_hit = '0;

      if (bus.new_game) begin
         state_d       = StPlay;
         lives_d       = StartLivesV;
         score_d       = '0;
         bonus_given_d = 1'b0;
         invuln_d      = '0;
         game_over_d   = 1'b0;
      end else if (state_q != StOver) begin
         // Score and bonus settle first so a simultaneous hit sees the bonus life.
         if (bus.alien_hit) begin
            score_d = score_sat;
            if (!bonus_given_q && (score_q < BonusV) && (score_sat >= BonusV)) begin
               bonus_given_d = 1'b1;
               if (lives_q < MaxLivesV) lives_d = lives_q + LivesW'(1);
            end
         end

         if (state_q == StInvuln) begin
            if (invuln_q == '0) state_d = StPlay;
            else                invuln_d = invuln_q - InvW'(1);
         end

         if ((state_q == StPlay) && bus.player_hit) begin
            lives_after_hit = lives_d - LivesW'(1);
            lives_d         = lives_after_hit;
            life_lost_d     = 1'b1;
            if (lives_after_hit == '0) begin
               state_d     = StOver;
               game_over_d = 1'b1;
            end else begin
               state_d  = StInvuln;
               invuln_d = InvLoad;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (arst) begin
         state_q       <= StPlay;
         lives_q       <= StartLivesV;
         score_q       <= '0;
         bonus_given_q <= 1'b0;
         invuln_q      <= '0;
         game_over_q   <= 1'b0;
         life_lost_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         lives_q       <= lives_d;
         score_q       <= score_d;
         bonus_given_q <= bonus_given_d;
         invuln_q      <= invuln_d;
         game_over_q   <= game_over_d;
         life_lost_q   <= life_lost_d;
      end
   end

   // Divider is reset only by arst; new_game leaves it free-running.
   tick_divider #(
      .Div (DispDiv)
   ) u_tick_divider (
      .clk  (clk),
      .arst (arst),
      .tick (clk_display)
   );

   assign bus.lives       = lives_q;
   assign bus.score       = score_q;
   assign bus.game_over   = game_over_q;
   assign bus.life_lost   = life_lost_q;
   assign bus.clk_display = clk_display;

endmodule

// File: tb/tb_game_stats.sv
// Directed scenario bench for game_stats with shortened invulnerability and display periods.
module tb_game_stats;
   import game_stats_pkg::*;

   localparam int unsigned DispDiv      = 10;
   localparam int unsigned InvulnCycles = 20;

   logic clk;
   logic arst;
   int   n_tests;
   int   n_fail;

   game_stats_if bus ();

   game_stats #(
      .InvulnCycles (InvulnCycles),
      .DispDiv      (DispDiv)
   ) dut (
      .clk  (clk),
      .arst (arst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Present one cycle of events, let the edge sample them, then clear.
   task automatic fire(input logic ng, input logic ah, input logic [3:0] pts, input logic ph);
      bus.new_game   = ng;
      bus.alien_hit  = ah;
      bus.alien_pts  = pts;
      bus.player_hit = ph;
      step();
      bus.new_game   = 1'b0;
      bus.alien_hit  = 1'b0;
      bus.alien_pts  = 4'd0;
      bus.player_hit = 1'b0;
   endtask

   task automatic test_reset();
      int pulses;
      logic exp_cd;
      arst = 1'b1;
      step();
      arst = 1'b0;
      n_tests++;
      if (bus.lives !== 4'd3) begin
         n_fail++; $display("FAIL reset_lives got %0d want 3", bus.lives);
      end
      n_tests++;
      if (bus.score !== 7'd0) begin
         n_fail++; $display("FAIL reset_score got %0d want 0", bus.score);
      end
      n_tests++;
      if (bus.game_over !== 1'b0 || bus.life_lost !== 1'b0 || bus.clk_display !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags got go=%b ll=%b cd=%b want 0 0 0",
                  bus.game_over, bus.life_lost, bus.clk_display);
      end
      pulses = 0;
      for (int k = 1; k <= 3 * DispDiv; k++) begin
         step();
         exp_cd = ((k % DispDiv) == 0);
         n_tests++;
         if (bus.clk_display !== exp_cd) begin
            n_fail++; $display("FAIL idle_strobe k=%0d got %b want %b", k, bus.clk_display, exp_cd);
         end
         if (bus.clk_display === 1'b1) pulses++;
      end
      n_tests++;
      if (pulses != 3) begin
         n_fail++; $display("FAIL strobe_count got %0d want 3", pulses);
      end
      n_tests++;
      if (bus.lives !== 4'd3 || bus.score !== 7'd0 || bus.game_over !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_state got lives=%0d score=%0d go=%b want 3 0 0",
                  bus.lives, bus.score, bus.game_over);
      end
   endtask

   task automatic test_score();
      logic [6:0] exp_s;
      logic [3:0] exp_l;
      fire(1'b0, 1'b1, 4'd0, 1'b0);
      n_tests++;
      if (bus.score !== 7'd0 || bus.lives !== 4'd3) begin
         n_fail++; $display("FAIL zero_pts got score=%0d lives=%0d want 0 3", bus.score, bus.lives);
      end
      for (int i = 1; i <= 8; i++) begin
         fire(1'b0, 1'b1, 4'd10, 1'b0);
         exp_s = 7'(10 * i);
         exp_l = (i >= 5) ? 4'd4 : 4'd3;
         n_tests++;
         if (bus.score !== exp_s || bus.lives !== exp_l) begin
            n_fail++;
            $display("FAIL score_step i=%0d got score=%0d lives=%0d want %0d %0d",
                     i, bus.score, bus.lives, exp_s, exp_l);
         end
      end
      fire(1'b0, 1'b1, 4'd15, 1'b0);
      n_tests++;
      if (bus.score !== 7'd95 || bus.lives !== 4'd4) begin
         n_fail++; $display("FAIL score_95 got score=%0d lives=%0d want 95 4", bus.score, bus.lives);
      end
      fire(1'b0, 1'b1, 4'd15, 1'b0);
      n_tests++;
      if (bus.score !== 7'd99 || bus.lives !== 4'd4) begin
         n_fail++; $display("FAIL score_sat got score=%0d lives=%0d want 99 4", bus.score, bus.lives);
      end
   endtask

   task automatic test_invuln();
      fire(1'b1, 1'b0, 4'd0, 1'b0);
      n_tests++;
      if (bus.lives !== 4'd3 || bus.score !== 7'd0) begin
         n_fail++; $display("FAIL new_game got lives=%0d score=%0d want 3 0", bus.lives, bus.score);
      end
      fire(1'b0, 1'b0, 4'd0, 1'b1);  // edge N
      n_tests++;
      if (bus.lives !== 4'd2 || bus.life_lost !== 1'b1) begin
         n_fail++; $display("FAIL first_hit got lives=%0d ll=%b want 2 1", bus.lives, bus.life_lost);
      end
      step();                        // N+1
      n_tests++;
      if (bus.life_lost !== 1'b0) begin
         n_fail++; $display("FAIL ll_width got %b want 0", bus.life_lost);
      end
      idle(8);
      fire(1'b0, 1'b0, 4'd0, 1'b1);  // N+10
      n_tests++;
      if (bus.lives !== 4'd2 || bus.life_lost !== 1'b0) begin
         n_fail++; $display("FAIL hit_in_invuln got lives=%0d ll=%b want 2 0", bus.lives, bus.life_lost);
      end
      idle(9);
      fire(1'b0, 1'b0, 4'd0, 1'b1);  // N+20, last ignored cycle
      n_tests++;
      if (bus.lives !== 4'd2 || bus.life_lost !== 1'b0) begin
         n_fail++; $display("FAIL hit_invuln_end got lives=%0d ll=%b want 2 0", bus.lives, bus.life_lost);
      end
      fire(1'b0, 1'b0, 4'd0, 1'b1);  // N+21
      n_tests++;
      if (bus.lives !== 4'd1 || bus.life_lost !== 1'b1) begin
         n_fail++; $display("FAIL hit_after_invuln got lives=%0d ll=%b want 1 1", bus.lives, bus.life_lost);
      end
   endtask

   task automatic test_simultaneous();
      idle(21);
      for (int i = 0; i < 3; i++) fire(1'b0, 1'b1, 4'd15, 1'b0);
      n_tests++;
      if (bus.score !== 7'd45 || bus.lives !== 4'd1) begin
         n_fail++; $display("FAIL pre_simul got score=%0d lives=%0d want 45 1", bus.score, bus.lives);
      end
      fire(1'b0, 1'b1, 4'd5, 1'b1);
      n_tests++;
      if (bus.score !== 7'd50 || bus.lives !== 4'd1 || bus.game_over !== 1'b0 ||
          bus.life_lost !== 1'b1) begin
         n_fail++;
         $display("FAIL simul got score=%0d lives=%0d go=%b ll=%b want 50 1 0 1",
                  bus.score, bus.lives, bus.game_over, bus.life_lost);
      end
      fire(1'b0, 1'b0, 4'd0, 1'b1);
      n_tests++;
      if (bus.lives !== 4'd1 || bus.life_lost !== 1'b0) begin
         n_fail++; $display("FAIL simul_invuln got lives=%0d ll=%b want 1 0", bus.lives, bus.life_lost);
      end
   endtask

   task automatic test_game_over();
      idle(22);
      fire(1'b0, 1'b0, 4'd0, 1'b1);
      n_tests++;
      if (bus.lives !== 4'd0 || bus.game_over !== 1'b1 || bus.life_lost !== 1'b1) begin
         n_fail++;
         $display("FAIL last_life got lives=%0d go=%b ll=%b want 0 1 1",
                  bus.lives, bus.game_over, bus.life_lost);
      end
      fire(1'b0, 1'b1, 4'd7, 1'b1);
      n_tests++;
      if (bus.score !== 7'd50 || bus.lives !== 4'd0 || bus.game_over !== 1'b1 ||
          bus.life_lost !== 1'b0) begin
         n_fail++;
         $display("FAIL over_ignore got score=%0d lives=%0d go=%b ll=%b want 50 0 1 0",
                  bus.score, bus.lives, bus.game_over, bus.life_lost);
      end
      idle(25);
      n_tests++;
      if (bus.lives !== 4'd0 || bus.game_over !== 1'b1) begin
         n_fail++; $display("FAIL over_hold got lives=%0d go=%b want 0 1", bus.lives, bus.game_over);
      end
      fire(1'b1, 1'b0, 4'd0, 1'b0);
      n_tests++;
      if (bus.lives !== 4'd3 || bus.score !== 7'd0 || bus.game_over !== 1'b0) begin
         n_fail++;
         $display("FAIL restart got lives=%0d score=%0d go=%b want 3 0 0",
                  bus.lives, bus.score, bus.game_over);
      end
      for (int i = 0; i < 5; i++) fire(1'b0, 1'b1, 4'd10, 1'b0);
      n_tests++;
      if (bus.score !== 7'd50 || bus.lives !== 4'd4) begin
         n_fail++; $display("FAIL bonus_rearm got score=%0d lives=%0d want 50 4", bus.score, bus.lives);
      end
   endtask

   task automatic test_reset_mid_invuln();
      logic exp_cd;
      fire(1'b0, 1'b1, 4'd15, 1'b0);
      fire(1'b0, 1'b1, 4'd12, 1'b0);
      fire(1'b0, 1'b0, 4'd0, 1'b1);
      n_tests++;
      if (bus.score !== 7'd77 || bus.lives !== 4'd3 || bus.life_lost !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_arst got score=%0d lives=%0d ll=%b want 77 3 1",
                  bus.score, bus.lives, bus.life_lost);
      end
      idle(3);
      arst = 1'b1;
      step();
      arst = 1'b0;
      n_tests++;
      if (bus.lives !== 4'd3 || bus.score !== 7'd0 || bus.game_over !== 1'b0 ||
          bus.life_lost !== 1'b0 || bus.clk_display !== 1'b0) begin
         n_fail++;
         $display("FAIL arst_vals got lives=%0d score=%0d go=%b ll=%b cd=%b want 3 0 0 0 0",
                  bus.lives, bus.score, bus.game_over, bus.life_lost, bus.clk_display);
      end
      for (int k = 1; k <= DispDiv; k++) begin
         bus.player_hit = (k == 1);
         step();
         bus.player_hit = 1'b0;
         if (k == 1) begin
            n_tests++;
            if (bus.lives !== 4'd2 || bus.life_lost !== 1'b1) begin
               n_fail++;
               $display("FAIL arst_play got lives=%0d ll=%b want 2 1", bus.lives, bus.life_lost);
            end
         end
         exp_cd = (k == DispDiv);
         n_tests++;
         if (bus.clk_display !== exp_cd) begin
            n_fail++; $display("FAIL arst_div k=%0d got %b want %b", k, bus.clk_display, exp_cd);
         end
      end
   endtask

   initial begin
      n_tests        = 0;
      n_fail         = 0;
      arst           = 1'b0;
      bus.new_game   = 1'b0;
      bus.alien_hit  = 1'b0;
      bus.alien_pts  = 4'd0;
      bus.player_hit = 1'b0;
      test_reset();
      test_score();
      test_invuln();
      test_simultaneous();
      test_game_over();
      test_reset_mid_invuln();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
